// File: rtl/mem_access_pkg.sv
// Shared types and codes for the MEM-stage load/store sequencer.
package mem_access_pkg;

    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mem_op_e;

    localparam logic [2:0] CUT_WORD = 3'b000;
    localparam logic [2:0] CUT_HALF = 3'b001;
    localparam logic [2:0] CUT_BYTE = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_e;

    // Access width implied by an op code.
    function automatic size_e op_size(input logic [2:0] op);
        case (mem_op_e'(op))
            OP_LW, OP_SW:         return SZ_WORD;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Byte-lane steering: enables, store replication, load right-justify, alignment check.
module lane_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    // Enables, replicated store data and alignment by access width.
    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        misaligned_o = 1'b0;
        case (op_size(op_i))
            SZ_WORD: misaligned_o = (addr_lo_i != 2'b00);
            SZ_HALF: begin
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            default: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
        endcase
    end

    // Addressed lane moved down to bit 0; upper bits left for the cutter to mask.
    assign rdata_o = rdata_i >> {addr_lo_i, 3'b000};

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer with req/ack data-memory handshake and timeout.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [31:0] load_data,
    output logic [2:0]  cut_select,
    output logic        cut_sign,
    output logic        load_valid,
    output logic        addr_err,
    output logic        bus_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              store_q, store_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       ldata_q, ldata_d;

    logic              is_idle;
    logic [2:0]        la_op;
    logic [1:0]        la_addr;
    logic [31:0]       la_wdata;
    logic [3:0]        la_be;
    logic [31:0]       la_wdata_sh;
    logic [31:0]       la_rdata_sh;
    logic              la_mis;

    // Lane logic sees live inputs while idle (alignment check) and latched ones after.
    assign is_idle  = (state_q == ST_IDLE);
    assign la_op    = is_idle ? mem_op     : op_q;
    assign la_addr  = is_idle ? addr[1:0]  : addr_q[1:0];
    assign la_wdata = is_idle ? wdata      : wdata_q;

    lane_align u_lane_align (
        .op_i         (la_op),
        .addr_lo_i    (la_addr),
        .wdata_i      (la_wdata),
        .rdata_i      (dmem_rdata),
        .be_o         (la_be),
        .wdata_o      (la_wdata_sh),
        .rdata_o      (la_rdata_sh),
        .misaligned_o (la_mis)
    );

    // State, timeout counter and latched access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            store_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            store_q <= store_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ldata_q <= ldata_d;
        end
    end

    // Next state and handshake/pipeline outputs; everything quiet while in reset.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        store_d    = store_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ldata_d    = ldata_q;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = '0;
        dmem_wdata = '0;
        stall      = 1'b0;
        load_valid = 1'b0;
        addr_err   = 1'b0;
        bus_err    = 1'b0;
        cut_select = CUT_WORD;
        cut_sign   = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (mem_read || mem_write) begin
                        if (la_mis) begin
                            addr_err = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            op_d    = mem_op;
                            store_d = mem_write;
                            addr_d  = addr;
                            wdata_d = wdata;
                            state_d = ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    stall = 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        bus_err = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        dmem_req   = 1'b1;
                        dmem_we    = store_q;
                        dmem_addr  = {addr_q[31:2], 2'b00};
                        dmem_be    = la_be;
                        dmem_wdata = la_wdata_sh;
                        if (dmem_ack) begin
                            if (!store_q) ldata_d = la_rdata_sh;
                            cnt_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    load_valid = !store_q;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            if (!is_idle && !store_q) begin
                case (op_size(op_q))
                    SZ_HALF: cut_select = CUT_HALF;
                    SZ_BYTE: cut_select = CUT_BYTE;
                    default: cut_select = CUT_WORD;
                endcase
                cut_sign = (mem_op_e'(op_q) == OP_LH) || (mem_op_e'(op_q) == OP_LB);
            end
        end
    end

    assign load_data = ldata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Transaction-level reference bench for mem_access_ctrl.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    localparam int TO = 16;
    localparam int P_STALL_LEN = 1;
    localparam int P_BE        = 2;
    localparam int P_LD8       = 3;
    localparam int P_WDATA     = 4;
    localparam int P_REQ_LEN   = 5;

    logic        clk = 1'b0;
    logic        rst, mem_read, mem_write, dmem_ack;
    logic [2:0]  mem_op;
    logic [31:0] addr, wdata, dmem_rdata;
    logic        dmem_req, dmem_we, stall, cut_sign, load_valid, addr_err, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, load_data;
    logic [3:0]  dmem_be;
    logic [2:0]  cut_select;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_op(mem_op), .addr(addr), .wdata(wdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall(stall), .load_data(load_data),
        .cut_select(cut_select), .cut_sign(cut_sign), .load_valid(load_valid),
        .addr_err(addr_err), .bus_err(bus_err)
    );

    typedef struct {
        bit          skip;
        bit          req, we, stall, lv, sg, aerr, berr;
        logic [31:0] a, wd, ld, ld_mask;
        logic [3:0]  be;
        logic [2:0]  cs;
        int          pk0, pk1;
        logic [31:0] pv0, pv1;
    } exp_t;

    exp_t q[$];
    exp_t ce;
    int total = 0;
    int bad = 0;
    int stall_run = 0, last_stall = 0, req_run = 0, last_req = 0;

    int pr_k0, pr_k1, pd_k0, pd_k1, pb_k;
    logic [31:0] pr_v0, pr_v1, pd_v0, pd_v1, pb_v;

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", n, act, want, $time);
        end
    endfunction

    function automatic void pin(input int k, input logic [31:0] v);
        case (k)
            P_STALL_LEN: chk("pin_stall_len", 32'(last_stall), v);
            P_BE:        chk("pin_be", 32'(dmem_be), v);
            P_LD8:       chk("pin_ld8", 32'(load_data[7:0]), v);
            P_WDATA:     chk("pin_wdata", dmem_wdata, v);
            P_REQ_LEN:   chk("pin_req_len", 32'(last_req), v);
            default: ;
        endcase
    endfunction

    // Compare process: one expectation per cycle, checked at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                ce = q.pop_front();
                if (!ce.skip) begin
                    chk("dmem_req", 32'(dmem_req), 32'(ce.req));
                    if (ce.req) begin
                        chk("dmem_we", 32'(dmem_we), 32'(ce.we));
                        chk("dmem_addr", dmem_addr, ce.a);
                        chk("dmem_be", 32'(dmem_be), 32'(ce.be));
                        chk("dmem_wdata", dmem_wdata, ce.wd);
                    end
                    chk("stall", 32'(stall), 32'(ce.stall));
                    chk("load_valid", 32'(load_valid), 32'(ce.lv));
                    chk("cut_select", 32'(cut_select), 32'(ce.cs));
                    chk("cut_sign", 32'(cut_sign), 32'(ce.sg));
                    chk("addr_err", 32'(addr_err), 32'(ce.aerr));
                    chk("bus_err", 32'(bus_err), 32'(ce.berr));
                    if (ce.ld_mask != 0) chk("load_data", load_data & ce.ld_mask, ce.ld & ce.ld_mask);
                end
                if (stall) stall_run++;
                else begin
                    if (stall_run != 0) last_stall = stall_run;
                    stall_run = 0;
                end
                if (dmem_req) req_run++;
                else begin
                    if (req_run != 0) last_req = req_run;
                    req_run = 0;
                end
                pin(ce.pk0, ce.pv0);
                pin(ce.pk1, ce.pv1);
            end
        end
    end

    function automatic exp_t blank();
        exp_t e;
        e.skip = 0; e.req = 0; e.we = 0; e.stall = 0; e.lv = 0; e.sg = 0;
        e.aerr = 0; e.berr = 0; e.a = 0; e.wd = 0; e.ld = 0; e.ld_mask = 0;
        e.be = 0; e.cs = 0; e.pk0 = 0; e.pk1 = 0; e.pv0 = 0; e.pv1 = 0;
        return e;
    endfunction

    function automatic int nbytes(input logic [2:0] op);
        if (op == OP_LW || op == OP_SW) return 4;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 1;
    endfunction

    task automatic clear_pins();
        pr_k0 = 0; pr_k1 = 0; pd_k0 = 0; pd_k1 = 0; pb_k = 0;
        pr_v0 = 0; pr_v1 = 0; pd_v0 = 0; pd_v1 = 0; pb_v = 0;
    endtask

    task automatic drive(input bit r, input bit w, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input bit ack, input logic [31:0] rd, input exp_t e);
        mem_read = r; mem_write = w; mem_op = op; addr = a; wdata = wd;
        dmem_ack = ack; dmem_rdata = rd;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Inputs the controller must ignore while busy are scrambled.
    task automatic drive_junk(input bit ack, input logic [31:0] rd, input exp_t e);
        drive(1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom, ack, rd, e);
    endtask

    task automatic idle_step(input int pk, input logic [31:0] pv);
        exp_t e;
        e = blank();
        e.pk0 = pk; e.pv0 = pv;
        drive(0, 0, 3'($urandom), $urandom, $urandom, 1'($urandom), $urandom, e);
    endtask

    // One access from the start cycle through DONE (or bus_err); lat=0 means no ack.
    task automatic txn(input bit r, input bit w, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input logic [31:0] rd);
        exp_t e;
        int n, lo, nreq;
        logic [31:0] wrep, mask;
        logic [3:0] be;
        logic [2:0] cs;
        bit sg, st;
        n  = nbytes(op);
        lo = int'(a[1:0]);
        st = w;
        be = 4'(((1 << n) - 1) << lo);
        for (int b = 0; b < 4; b++) wrep[8*b +: 8] = wd[8*(b % n) +: 8];
        mask = (n == 4) ? 32'hFFFF_FFFF : (n == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
        cs = st ? 3'b000 : (n == 4) ? 3'b000 : (n == 2) ? 3'b001 : 3'b010;
        sg = !st && (op == OP_LH || op == OP_LB);
        e = blank();
        if ((lo % n) != 0) begin
            e.aerr = 1;
            drive(r, w, op, a, wd, 1'($urandom), $urandom, e);
            return;
        end
        e.stall = 1;
        drive(r, w, op, a, wd, 1'($urandom), $urandom, e);
        nreq = (lat == 0) ? TO : lat;
        for (int k = 1; k <= nreq; k++) begin
            e = blank();
            e.req = 1; e.we = st; e.a = {a[31:2], 2'b00}; e.be = be; e.wd = wrep;
            e.stall = 1; e.cs = cs; e.sg = sg;
            if (k == 1) begin e.pk0 = pr_k0; e.pv0 = pr_v0; e.pk1 = pr_k1; e.pv1 = pr_v1; end
            drive_junk(k == lat, (k == lat) ? rd : $urandom, e);
        end
        e = blank();
        e.cs = cs; e.sg = sg;
        if (lat == 0) begin
            e.stall = 1; e.berr = 1; e.pk0 = pb_k; e.pv0 = pb_v;
        end else begin
            e.lv = !st;
            e.ld = rd >> (8 * lo);
            e.ld_mask = st ? 32'h0 : mask;
            e.pk0 = pd_k0; e.pv0 = pd_v0; e.pk1 = pd_k1; e.pv1 = pd_v1;
        end
        drive_junk(1'($urandom), $urandom, e);
        clear_pins();
    endtask

    initial begin
        exp_t e;
        clear_pins();
        rst = 1; mem_read = 0; mem_write = 0; mem_op = 0; addr = 0; wdata = 0;
        dmem_ack = 0; dmem_rdata = 0;
        @(posedge clk);
        #1;
        e = blank(); e.skip = 1;
        drive(0, 0, 0, 0, 0, 0, 0, e);
        drive(0, 0, 0, 0, 0, 0, 0, e);
        rst = 0;
        e = blank(); e.ld_mask = 32'hFFFF_FFFF;
        drive(0, 0, 0, 0, 0, 0, 0, e);

        // LB at 0x1003, ack on third REQ cycle.
        pr_k0 = P_BE; pr_v0 = 32'h8;
        pd_k0 = P_STALL_LEN; pd_v0 = 4; pd_k1 = P_LD8; pd_v1 = 32'h80;
        txn(1, 0, OP_LB, 32'h0000_1003, 32'h0, 3, 32'h80FF_FF7F);
        idle_step(0, 0);

        // SH at 0x2002, ack in first REQ cycle.
        pr_k0 = P_BE; pr_v0 = 32'hC; pr_k1 = P_WDATA; pr_v1 = 32'hBEEF_BEEF;
        pd_k0 = P_STALL_LEN; pd_v0 = 2;
        txn(0, 1, OP_SH, 32'h0000_2002, 32'h0000_BEEF, 1, 32'h0);

        // Misaligned LW.
        txn(1, 0, OP_LW, 32'h0000_0006, 32'h0, 1, 32'h0);
        idle_step(0, 0);

        // LHU that never gets an ack.
        pb_k = P_REQ_LEN; pb_v = 16;
        txn(1, 0, OP_LHU, 32'h0000_0000, 32'h0, 0, 32'h0);
        idle_step(P_STALL_LEN, 18);

        // Reset during the second REQ cycle of an LW; the late ack must be dropped.
        e = blank(); e.stall = 1;
        drive(1, 0, OP_LW, 32'h0000_0040, 0, 0, 0, e);
        e = blank(); e.req = 1; e.a = 32'h40; e.be = 4'hF; e.stall = 1;
        drive(0, 0, OP_LW, 32'h0000_0040, 0, 0, 0, e);
        rst = 1;
        e = blank(); e.skip = 1;
        drive(0, 0, OP_LW, 32'h0000_0040, 0, 0, 0, e);
        rst = 0;
        e = blank();
        drive(0, 0, OP_LW, 32'h0000_0040, 0, 1, 32'hDEAD_BEEF, e);
        idle_step(0, 0);

        // Read+write together is a store; LW follows right after DONE.
        pr_k0 = P_BE; pr_v0 = 32'hF; pr_k1 = P_WDATA; pr_v1 = 32'h1234_5678;
        txn(1, 1, OP_SW, 32'h0000_0010, 32'h1234_5678, 2, 32'h0);
        txn(1, 0, OP_LW, 32'h0000_0020, 32'h0, 1, 32'hCAFE_F00D);
        idle_step(0, 0);

        // Randomized accesses.
        for (int i = 0; i < 200; i++) begin
            logic [2:0] op;
            bit r, w;
            int lat;
            op = 3'($urandom);
            w = (op >= OP_SW);
            r = !w || ($urandom_range(0, 3) == 0);
            lat = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 5);
            txn(r, w, op, $urandom, $urandom, lat, $urandom);
            repeat ($urandom_range(0, 2)) idle_step(0, 0);
        end
        idle_step(0, 0);
        idle_step(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
